// File: rtl/prio_arbiter8_if.sv
// Handshake bundle between the eight request sources and prio_arbiter8.
// The master side drives requests and ACK; the slave side (the arbiter) drives the grant.
interface prio_arbiter8_if;
  logic       EI;
  logic [7:0] REQ;
  logic       ACK;
  logic [2:0] Y;
  logic       GS;
  logic       EO;
  logic [7:0] PEND;

  modport master (output EI, REQ, ACK, input Y, GS, EO, PEND);
  modport slave  (input EI, REQ, ACK, output Y, GS, EO, PEND);
endinterface

// File: rtl/prio_arbiter8.sv
// Eight-input latched-request arbiter with Y/GS/EO priority-encoder style outputs.
// Define PRIO_ARBITER8_RR_EN for rotating priority; the default build is fixed priority (bit 7 highest).
module prio_arbiter8 (
  input  logic            clk,
  input  logic            rst,
  prio_arbiter8_if.slave  bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] clr;
  logic [2:0] y_q, y_d;
  logic [2:0] win;

`ifdef PRIO_ARBITER8_RR_EN
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx;

  // Walk from the pointer itself (k=8) up to ptr-1 (k=1); the last hit is the most urgent.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = 8; k >= 1; k--) begin
      idx = ptr_q - 3'(k);
      if (pend_q[idx]) win = idx;
    end
  end
`else
  // Ascending scan so the highest set index wins.
  always_comb begin
    win = '0;
    for (int i = 0; i < 8; i++)
      if (pend_q[i]) win = 3'(i);
  end
`endif

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    clr     = '0;
`ifdef PRIO_ARBITER8_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.EI && (pend_q != '0)) begin
          y_d     = win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (bus.ACK) begin
          clr     = 8'b1 << y_q;
          state_d = IDLE;
`ifdef PRIO_ARBITER8_RR_EN
          ptr_d   = y_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // Set wins over clear when the grantee re-requests in its ACK cycle.
    pend_d = (pend_q & ~clr) | bus.REQ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      y_q     <= '0;
`ifdef PRIO_ARBITER8_RR_EN
      ptr_q   <= 3'd7;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      y_q     <= y_d;
`ifdef PRIO_ARBITER8_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.Y    = y_q;
  assign bus.GS   = (state_q == GRANT);
  assign bus.PEND = pend_q;
  assign bus.EO   = bus.EI & (state_q != GRANT) & (pend_q == '0);
endmodule

// File: tb/tb_prio_arbiter8.sv
// Scoreboard bench for prio_arbiter8: a cycle model pushes expected outputs as stimulus is
// driven; they are popped and compared one edge later. Follows PRIO_ARBITER8_RR_EN like the RTL.
module tb_prio_arbiter8;
  logic clk = 1'b0;
  logic rst;
  prio_arbiter8_if bus();

  prio_arbiter8 dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] y;
    logic       gs;
    logic [7:0] pend;
    logic       eo;
  } exp_t;

  exp_t       sbq[$];
  logic [2:0] gnt_q[$];
  logic [2:0] exp_seq[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       prev_gs;

  // reference state
  logic [7:0] m_pend;
  logic [2:0] m_y;
  logic       m_gs;
  logic [2:0] m_ptr;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] pick(input logic [7:0] p, input logic [2:0] ptr);
    logic [2:0] r;
    logic       found;
    r = '0;
    found = 1'b0;
`ifdef PRIO_ARBITER8_RR_EN
    for (int s = 1; s <= 8; s++) begin
      if (!found && p[(int'(ptr) + 8 - s) % 8]) begin
        r = 3'((int'(ptr) + 8 - s) % 8);
        found = 1'b1;
      end
    end
`else
    ptr = ptr;
    for (int i = 7; i >= 0; i--) begin
      if (!found && p[i]) begin
        r = 3'(i);
        found = 1'b1;
      end
    end
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_y = '0; m_gs = 1'b0; m_ptr = 3'd7;
    prev_gs = 1'b0;
  endtask

  task automatic model_tick(input logic ei, input logic [7:0] req, input logic ack);
    logic [7:0] clr;
    logic [7:0] npend;
    clr = '0;
    if (m_gs && ack) clr[m_y] = 1'b1;
    npend = (m_pend & ~clr) | req;
    if (!m_gs) begin
      if (ei && m_pend != 8'h00) begin
        m_y  = pick(m_pend, m_ptr);
        m_gs = 1'b1;
      end
    end else if (ack) begin
      m_ptr = m_y;
      m_gs  = 1'b0;
    end
    m_pend = npend;
  endtask

  task automatic step(input logic ei, input logic [7:0] req, input logic ack);
    exp_t e;
    @(negedge clk);
    bus.EI = ei; bus.REQ = req; bus.ACK = ack;
    model_tick(ei, req, ack);
    e.y = m_y; e.gs = m_gs; e.pend = m_pend; e.eo = ei & ~m_gs & (m_pend == 8'h00);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("Y",    8'(bus.Y),  8'(e.y));
    chk("GS",   8'(bus.GS), 8'(e.gs));
    chk("PEND", bus.PEND,   e.pend);
    chk("EO",   8'(bus.EO), 8'(e.eo));
    if (bus.GS && !prev_gs) gnt_q.push_back(bus.Y);
    prev_gs = bus.GS;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.EI = 1'b1; bus.REQ = '0; bus.ACK = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_GS",   8'(bus.GS), 8'h00);
    chk("rst_Y",    8'(bus.Y),  8'h00);
    chk("rst_PEND", bus.PEND,   8'h00);
    chk("rst_EO",   8'(bus.EO), 8'h01);
    #2 rst = 1'b0;
    gnt_q.delete();
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_len"}, 8'(gnt_q.size()), 8'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < gnt_q.size(); i++)
      chk(tag, 8'(gnt_q[i]), 8'(exp_seq[i]));
  endtask

  initial begin
    rst = 1'b1;
    bus.EI = 1'b1; bus.REQ = '0; bus.ACK = 1'b0;
    model_reset();
    #1;
    chk("init_GS",   8'(bus.GS), 8'h00);
    chk("init_PEND", bus.PEND,   8'h00);
    chk("init_EO",   8'(bus.EO), 8'h01);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // single request
    step(1'b1, 8'h10, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    chk("single_Y", 8'(bus.Y), 8'h04);
    step(1'b1, 8'h00, 1'b1);
    chk("single_EO", 8'(bus.EO), 8'h01);

    // reset mid-grant, asserted between edges
    do_reset();
    step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    chk("mid_Y5", 8'(bus.Y), 8'h05);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("mid_GS",   8'(bus.GS), 8'h00);
    chk("mid_Y",    8'(bus.Y),  8'h00);
    chk("mid_PEND", bus.PEND,   8'h00);
    chk("mid_EO",   8'(bus.EO), 8'h01);
    #1 rst = 1'b0;

    // PEND=85 drained with ACK tied high
    do_reset();
    step(1'b0, 8'h85, 1'b0);
    repeat (7) step(1'b1, 8'h00, 1'b1);
`ifdef PRIO_ARBITER8_RR_EN
    exp_seq = '{3'd2, 3'd0, 3'd7};
`else
    exp_seq = '{3'd7, 3'd2, 3'd0};
`endif
    chk_seq("seq85");
    chk("seq85_EO", 8'(bus.EO), 8'h01);

    // all requesters held, ACK tied high
    do_reset();
    repeat (18) step(1'b1, 8'hFF, 1'b1);
`ifdef PRIO_ARBITER8_RR_EN
    exp_seq = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
`else
    exp_seq = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif
    chk_seq("seqFF");

    // enable gating, grant held across EI drop, set-wins on ACK
    do_reset();
    step(1'b0, 8'h01, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("en_GS0", 8'(bus.GS), 8'h00);
    chk("en_EO0", 8'(bus.EO), 8'h00);
    step(1'b1, 8'h00, 1'b0);
    chk("en_Y0", 8'(bus.Y), 8'h00);
    step(1'b0, 8'h00, 1'b0);
    chk("hold_GS", 8'(bus.GS), 8'h01);
    step(1'b1, 8'h01, 1'b1);
    chk("setwin_PEND", bus.PEND, 8'h01);
    step(1'b1, 8'h00, 1'b0);
    chk("regrant_GS", 8'(bus.GS), 8'h01);
    step(1'b1, 8'h00, 1'b1);

    // ACK while idle
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'h00, 1'b1);
    chk("idleack_GS", 8'(bus.GS), 8'h00);
    chk("idleack_PEND", bus.PEND, 8'h00);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step(($urandom_range(0, 7) != 0), r, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
